fir_filter_param: RTL and testbench

Parametrised, runtime-programmable FIR filter that succeeds the fixed 8-bit filter model in the DSP filter chain. It takes one signed sample per enabled clock, runs it through a TAPS-deep delay line with writable coefficients, and produces rounded, optionally saturated output with a 2-enabled-cycle pipeline. It uses the same clk / clk_enable / ce_out framing as the existing filter, so benches drive it sample-per-enable and compare against golden vectors.

---
 rtl/fir_filter_param.sv | 111 +++++++++++
 tb/tb_fir_filter_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// FIR filter: TAPS-deep delay line, runtime-writable coefficients, rounded and optionally saturated output.
// Latency: 2 enabled edges from sample capture to y (delay line -> products -> sum/round/range).
// Backpressure: none; clk_enable stalls the datapath, coefficient writes and ovf_clr act regardless.
module fir_filter_param #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int TAPS = 8,
    parameter int FRAC = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clk_enable,
    input  logic signed [DW-1:0]       x,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [CW-1:0]       coef_wdata,
    input  logic                       sat_en,
    input  logic                       ovf_clr,
    output logic signed [DW-1:0]       y,
    output logic                       ce_out,
    output logic                       ovf
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = DW + CW;
    localparam int SW = DW + CW + AW;
    // One extra bit so adding the rounding constant can never wrap.
    localparam int RW = SW + 1;

    localparam logic signed [RW-1:0] RND   = RW'(1) << (FRAC - 1);
    localparam logic signed [RW-1:0] YMAX  = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] YMIN  = -RW'(2 ** (DW - 1));
    localparam logic signed [CW-1:0] C_ONE = CW'(2 ** FRAC);

    logic signed [DW-1:0] d [TAPS];
    logic signed [CW-1:0] c [TAPS];
    logic signed [PW-1:0] p [TAPS];
    logic signed [SW-1:0] acc;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r;
    logic                 oor;
    logic signed [DW-1:0] y_nxt;
    logic [1:0]           prime_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                d[k] <= '0;
                p[k] <= '0;
            end
        end else if (clk_enable) begin
            d[0] <= x;
            for (int k = 1; k < TAPS; k++) begin
                d[k] <= d[k-1];
            end
            for (int k = 0; k < TAPS; k++) begin
                p[k] <= PW'(c[k]) * PW'(d[k]);
            end
        end
    end

    // Coefficient writes are independent of clk_enable; the P stage samples c before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                c[k] <= (k == 0) ? C_ONE : '0;
            end
        end else if (coef_we && (int'(coef_addr) < TAPS)) begin
            c[coef_addr] <= coef_wdata;
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + SW'(p[k]);
        end
        rnd = RW'(acc) + RND;
        r   = rnd >>> FRAC;
        oor = (r > YMAX) || (r < YMIN);
        if (oor && sat_en) begin
            y_nxt = r[RW-1] ? YMIN[DW-1:0] : YMAX[DW-1:0];
        end else begin
            y_nxt = r[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y         <= '0;
            ce_out    <= 1'b0;
            ovf       <= 1'b0;
            prime_cnt <= '0;
        end else begin
            if (clk_enable) begin
                y      <= y_nxt;
                ce_out <= (prime_cnt == 2'd2);
                if (prime_cnt != 2'd2) begin
                    prime_cnt <= prime_cnt + 2'd1;
                end
            end else begin
                ce_out <= 1'b0;
            end
            // A fresh overflow beats a simultaneous clear.
            if (clk_enable && oor) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_filter_param.sv
// Directed and randomized checks of fir_filter_param against a sample-history reference model.
module tb_fir_filter_param;
    localparam int DW = 8, CW = 8, TAPS = 8, FRAC = 6;
    localparam int DW2 = 12, CW2 = 10, TAPS2 = 6, FRAC2 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, clk_enable, coef_we, sat_en, ovf_clr;
    logic signed [DW-1:0] x;
    logic [2:0]           coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic signed [DW-1:0] y;
    logic                 ce_out, ovf;

    logic signed [DW2-1:0] x2;
    logic                  coef_we2;
    logic [2:0]            coef_addr2;
    logic signed [CW2-1:0] coef_wdata2;
    logic signed [DW2-1:0] y2;
    logic                  ce_out2, ovf2;

    int checks = 0;
    int errors = 0;

    longint m_c [TAPS];
    longint m_h [TAPS];
    longint m_pend, m_y;
    bit     m_ce, m_ovf;
    int     m_nen;
    longint c2 [TAPS2];

    fir_filter_param #(.DW(DW), .CW(CW), .TAPS(TAPS), .FRAC(FRAC)) u_dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .sat_en(sat_en), .ovf_clr(ovf_clr), .y(y), .ce_out(ce_out), .ovf(ovf)
    );

    fir_filter_param #(.DW(DW2), .CW(CW2), .TAPS(TAPS2), .FRAC(FRAC2)) u_dut2 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .x(x2),
        .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_wdata(coef_wdata2),
        .sat_en(sat_en), .ovf_clr(ovf_clr), .y(y2), .ce_out(ce_out2), .ovf(ovf2)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Round half up, then clamp or wrap to dw bits.
    task automatic rnd_sat(input longint acc, input bit sat, input int dw, input int frac,
                           output longint yo, output bit oor);
        longint r, lo, hi;
        r   = (acc + (longint'(1) << (frac - 1))) >>> frac;
        lo  = -(longint'(1) << (dw - 1));
        hi  = (longint'(1) << (dw - 1)) - 1;
        oor = (r < lo) || (r > hi);
        if (!oor) yo = r;
        else if (sat) yo = (r < lo) ? lo : hi;
        else begin
            yo = r & ((longint'(1) << dw) - 1);
            if (yo > hi) yo = yo - (longint'(1) << dw);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_c[k] = (k == 0) ? (longint'(1) << FRAC) : 0;
            m_h[k] = 0;
        end
        m_pend = 0; m_y = 0; m_ce = 0; m_ovf = 0; m_nen = 0;
    endtask

    // y after enabled edge n = rounded dot product of coefs (as before edge n-1) with samples up to edge n-2.
    task automatic model_edge();
        longint yo;
        bit     oor;
        if (!rst) begin
            model_reset();
            return;
        end
        if (clk_enable) begin
            rnd_sat(m_pend, sat_en, DW, FRAC, yo, oor);
            m_y = yo;
            if (oor) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_ce = (m_nen >= 2);
            if (m_nen < 2) m_nen++;
            m_pend = 0;
            for (int k = 0; k < TAPS; k++) m_pend += m_c[k] * m_h[k];
            for (int k = TAPS - 1; k > 0; k--) m_h[k] = m_h[k-1];
            m_h[0] = x;
        end else begin
            m_ce = 0;
            if (ovf_clr) m_ovf = 0;
        end
        if (coef_we && int'(coef_addr) < TAPS) m_c[coef_addr] = coef_wdata;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ":y"}, y, m_y);
        check({tag, ":ce_out"}, ce_out, m_ce);
        check({tag, ":ovf"}, ovf, m_ovf);
    endtask

    task automatic write_coef(input int addr, input int val);
        clk_enable = 0; coef_we = 1;
        coef_addr = 3'(addr); coef_wdata = CW'(val);
        cycle("coef_wr");
        coef_we = 0;
    endtask

    initial begin
        rst = 0; clk_enable = 0; coef_we = 0; sat_en = 0; ovf_clr = 0;
        x = 0; coef_addr = 0; coef_wdata = 0;
        x2 = 0; coef_we2 = 0; coef_addr2 = 0; coef_wdata2 = 0;
        model_reset();
        #1;
        check("reset:y", y, 0);
        check("reset:ce_out", ce_out, 0);
        check("reset:ovf", ovf, 0);
        check("reset:y2", y2, 0);
        cycle("in_reset");
        rst = 1;

        // Identity after reset
        clk_enable = 1; x = 8'sh40;
        cycle("id1"); check("id1:ce_const", ce_out, 0);
        x = 0;
        cycle("id2"); check("id2:ce_const", ce_out, 0);
        cycle("id3"); check("id3:y_const", y, 64); check("id3:ce_const", ce_out, 1);
        cycle("id4"); check("id4:y_const", y, 0);
        for (int i = 0; i < 6; i++) cycle("id_tail");

        // Moving average ramp, with an enable gap partway through
        for (int k = 0; k < TAPS; k++) write_coef(k, 8);
        clk_enable = 1; x = 8'sh40;
        cycle("ma_prime0"); cycle("ma_prime1");
        for (int i = 1; i <= 4; i++) begin
            cycle("ma_ramp");
            check("ma_ramp:y_const", y, 8 * i);
        end
        clk_enable = 0;
        for (int i = 0; i < 5; i++) begin
            x = DW'($urandom_range(0, 255));
            cycle("gap");
            check("gap:y_hold", y, 32);
            check("gap:ce_out", ce_out, 0);
        end
        clk_enable = 1; x = 8'sh40;
        for (int i = 5; i <= 8; i++) begin
            cycle("ma_resume");
            check("ma_resume:y_const", y, 8 * i);
        end
        for (int i = 0; i < 4; i++) cycle("ma_hold");
        check("ma_hold:y_const", y, 64);
        check("ma_hold:ovf", ovf, 0);

        // Randomized stream: data, enables, coef writes, sat mode, clears
        for (int i = 0; i < 300; i++) begin
            x          = DW'($urandom_range(0, 255));
            clk_enable = ($urandom_range(0, 3) != 0);
            coef_we    = ($urandom_range(0, 3) == 0);
            coef_addr  = 3'($urandom_range(0, 7));
            coef_wdata = CW'($urandom_range(0, 255));
            sat_en     = 1'($urandom_range(0, 1));
            ovf_clr    = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end
        coef_we = 0; ovf_clr = 0;

        // Saturation and wrap
        write_coef(0, 127);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
        ovf_clr = 1; clk_enable = 1; x = 0;
        for (int i = 0; i < 3; i++) cycle("sat_flush");
        ovf_clr = 0; sat_en = 1; x = 8'sh7f;
        for (int i = 0; i < 3; i++) cycle("sat_pos");
        check("sat_pos:y_const", y, 127); check("sat_pos:ovf_const", ovf, 1);
        sat_en = 0;
        for (int i = 0; i < 3; i++) cycle("wrap_pos");
        check("wrap_pos:y_const", y, -4);
        sat_en = 1; x = -8'sd128;
        for (int i = 0; i < 3; i++) cycle("sat_neg");
        check("sat_neg:y_const", y, -128);
        x = 0;
        for (int i = 0; i < 3; i++) cycle("ovf_sticky");
        check("ovf_sticky:ovf_const", ovf, 1); check("ovf_sticky:y_const", y, 0);
        ovf_clr = 1;
        cycle("ovf_clr"); check("ovf_clr:ovf_const", ovf, 0);
        x = 8'sh7f;
        for (int i = 0; i < 3; i++) cycle("ovf_set_wins");
        check("ovf_set_wins:ovf_const", ovf, 1);
        ovf_clr = 0;
        cycle("pre_reset");

        // Async reset between edges
        #2 rst = 0;
        #1;
        check("arst:y", y, 0);
        check("arst:ce_out", ce_out, 0);
        check("arst:ovf", ovf, 0);
        model_reset();
        cycle("arst_hold");
        rst = 1; sat_en = 0; x = 8'sh40;
        cycle("id_again1");
        x = 0;
        cycle("id_again2");
        cycle("id_again3"); check("id_again3:y_const", y, 64); check("id_again3:ce_const", ce_out, 1);
        cycle("id_again4"); check("id_again4:y_const", y, 0);

        // Second configuration: program taps, try out-of-range writes, impulse
        for (int k = 0; k < TAPS2; k++) begin
            c2[k] = longint'($urandom_range(0, 510)) - 255;
            coef_we2 = 1; coef_addr2 = 3'(k); coef_wdata2 = CW2'(c2[k]);
            cycle("cfg2_wr");
        end
        coef_addr2 = 3'd6; coef_wdata2 = CW2'(511); cycle("cfg2_bad6");
        coef_addr2 = 3'd7; coef_wdata2 = CW2'(511); cycle("cfg2_bad7");
        coef_we2 = 0;
        for (int i = 0; i < 3; i++) cycle("cfg2_settle");
        check("cfg2_idle:y2", y2, 0);
        x2 = 12'sd512;
        cycle("imp0");
        x2 = 0;
        cycle("imp1");
        for (int k = 0; k < TAPS2; k++) begin
            cycle("imp_tap");
            check($sformatf("imp_tap%0d:y2", k), y2, 2 * c2[k]);
            check("imp_tap:ce_out2", ce_out2, 1);
        end
        cycle("imp_end");
        check("imp_end:y2", y2, 0);
        check("imp_end:ovf2", ovf2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
